// File: rtl/ext_mem_responder.sv
// Word-organised external-memory responder: accepts level-held read/write requests,
// completes them after LATENCY cycles with a one-cycle mem_ready pulse, flags out-of-range addresses.
module ext_mem_responder #(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          mem_addr,
    input  logic                 en_ext_mem_re,
    input  logic                 en_ext_mem_wr,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 mem_ready,
    output logic                 mem_err,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    // Handshake: the initiator holds re/wr as a level until it sees mem_ready;
    // dropping both while busy aborts the access. mem_ready is a single-cycle pulse.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 wr_q, wr_d;
    logic                 in_range_q, in_range_d;
    logic [WORD_SIZE-1:0] data_out_q, data_out_d;
    logic                 ready_q, ready_d;
    logic                 err_q, err_d;

    logic [WORD_SIZE-1:0] ram [DEPTH_WORDS];
    logic [WORD_SIZE-1:0] ram_rdata;
    logic                 ram_we;
    logic [29:0]          off_w;
    logic                 req;

    // Word offset of (mem_addr - BASE_ADDR), including the borrow out of the byte bits.
    assign off_w = mem_addr[31:2] - BASE_ADDR[31:2]
                 - {29'd0, (mem_addr[1:0] < BASE_ADDR[1:0])};
    assign req       = en_ext_mem_re | en_ext_mem_wr;
    assign ram_rdata = ram[idx_q];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        wr_d       = wr_q;
        in_range_d = in_range_q;
        data_out_d = '0;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        ram_we     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d      = off_w[IDX_W-1:0];
                    in_range_d = (off_w < DEPTH_LIM);
                    data_d     = data_in;
                    wr_d       = en_ext_mem_wr;
                    cnt_d      = CNT_LOAD;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RESPOND;
                    ready_d = 1'b1;
                    err_d   = ~in_range_q;
                    if (wr_q) begin
                        ram_we = in_range_q;
                    end else if (in_range_q) begin
                        data_out_d = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            in_range_q <= 1'b0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            in_range_q <= in_range_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    // Memory contents survive reset; ram_we is gated by the reset-cleared state.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[idx_q] <= data_q;
        end
    end

    assign data_out  = data_out_q;
    assign mem_ready = ready_q;
    assign mem_err   = err_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder: table of single transactions plus
// hand-written sequences for held requests, aborts and asynchronous reset.
module tb_ext_mem_responder;

    localparam int W   = 32;
    localparam int LAT = 3;

    logic          clk;
    logic          rst_n;
    logic [31:0]   mem_addr;
    logic          en_re;
    logic          en_wr;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;
    logic          mem_ready;
    logic          mem_err;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    ext_mem_responder #(
        .WORD_SIZE(W),
        .DEPTH_WORDS(1024),
        .BASE_ADDR(32'h0000_0000),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_addr(mem_addr),
        .en_ext_mem_re(en_re),
        .en_ext_mem_wr(en_wr),
        .data_in(data_in),
        .data_out(data_out),
        .mem_ready(mem_ready),
        .mem_err(mem_err),
        .busy(busy),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic         wr;
        logic         re;
        logic [31:0]  addr;
        logic [W-1:0] data;
        logic [W-1:0] exp_dout;
        logic         exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one request and waits for mem_ready; lat counts edges from the accept edge (=1).
    task automatic run_txn(input logic wr, input logic re, input logic [31:0] addr,
                           input logic [W-1:0] data, output int lat,
                           output logic [W-1:0] dout, output logic err, output logic early_nz);
        @(negedge clk);
        en_wr = wr; en_re = re; mem_addr = addr; data_in = data;
        lat = -1; dout = '0; err = 1'b0; early_nz = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                lat = i; dout = data_out; err = mem_err;
                break;
            end
            if (data_out !== '0) early_nz = 1'b1;
        end
        en_wr = 1'b0; en_re = 1'b0;
    endtask

    initial begin
        int           lat;
        logic [W-1:0] dout;
        logic         err;
        logic         early_nz;
        int           pulses;
        int           pulse_at[2];
        logic [W-1:0] pulse_dout[2];
        logic         seen;

        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h00C0_FFEE, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h0,         1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h1234_5678, 32'h0,         1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0,         32'h0,         1'b1};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0FFF, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0BAD_BEEF, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,         32'h0BAD_BEEF, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0024, 32'h2424_2424, 32'h0,         1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};

        rst_n = 1'b0; en_re = 1'b0; en_wr = 1'b0; mem_addr = '0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", mem_ready, 0);
        check("reset_err",   mem_err,   0);
        check("reset_dout",  data_out,  0);
        check("reset_busy",  busy,      0);
        check("reset_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 13; v++) begin
            run_txn(vecs[v].wr, vecs[v].re, vecs[v].addr, vecs[v].data, lat, dout, err, early_nz);
            check($sformatf("v%0d_latency", v), lat, LAT + 1);
            check($sformatf("v%0d_dout", v), dout, vecs[v].exp_dout);
            check($sformatf("v%0d_err", v), err, vecs[v].exp_err);
            check($sformatf("v%0d_dout_before_ready", v), early_nz, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_ready_one_cycle", v), mem_ready, 0);
            check($sformatf("v%0d_dout_after", v), data_out, 0);
            check($sformatf("v%0d_idle_after", v), busy, 0);
        end

        // Read request held continuously: two reads, one IDLE cycle between them.
        @(negedge clk);
        en_re = 1'b1; mem_addr = 32'h0000_0010;
        pulses = 0; pulse_at = '{-1, -1}; pulse_dout = '{0, 0};
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                if (pulses < 2) begin
                    pulse_at[pulses] = i;
                    pulse_dout[pulses] = data_out;
                end
                pulses++;
                mem_addr = 32'h0000_0014;
            end
        end
        en_re = 1'b0;
        check("held_pulse_count", pulses, 2);
        check("held_first_at", pulse_at[0], LAT);
        check("held_second_at", pulse_at[1], 2 * LAT + 2);
        check("held_first_dout", pulse_dout[0], 32'hDEAD_BEEF);
        check("held_second_dout", pulse_dout[1], 32'h00C0_FFEE);
        repeat (3) @(posedge clk);
        #1;
        check("held_idle_after", busy, 0);

        // Abort: write request dropped after accept.
        @(negedge clk);
        en_wr = 1'b1; mem_addr = 32'h0000_0020; data_in = 32'hCAFE_F00D;
        @(posedge clk); #1;
        check("abort_busy_after_accept", busy, 1);
        en_wr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (mem_ready) seen = 1'b1;
        end
        check("abort_no_ready", seen, 0);
        check("abort_idle", busy, 0);
        run_txn(1'b0, 1'b1, 32'h0000_0020, 32'h0, lat, dout, err, early_nz);
        check("abort_old_value", dout, 32'h0BAD_BEEF);
        @(posedge clk); #1;

        // Asynchronous reset during the ready cycle clears outputs without an edge.
        @(negedge clk);
        en_re = 1'b1; mem_addr = 32'h0000_0010;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_respond_saw_ready", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_respond_ready", mem_ready, 0);
        check("rst_respond_dout", data_out, 0);
        check("rst_respond_busy", busy, 0);
        en_re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-BUSY drops the pending write.
        @(negedge clk);
        en_wr = 1'b1; mem_addr = 32'h0000_0024; data_in = 32'h9999_9999;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy_busy", busy, 0);
        check("rst_busy_ready", mem_ready, 0);
        check("rst_busy_dout", data_out, 0);
        check("rst_busy_state", dbg_state, 0);
        en_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1'b0, 1'b1, 32'h0000_0024, 32'h0, lat, dout, err, early_nz);
        check("rst_busy_no_commit", dout, 32'h2424_2424);
        check("rst_busy_read_latency", lat, LAT + 1);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
